// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant mux slice.
package rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Index width for n sources, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant_mux_if.sv
// Arbiter, source-stream and master-output signals of rr_grant_mux grouped as one bundle.
interface rr_grant_mux_if #(
    parameter int unsigned REQCNT = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned IW = rr_pkg::idx_w(REQCNT);

    logic [IW-1:0]            arb_num_i;
    logic                     arb_val_i;
    logic                     arb_ack_o;
    logic [REQCNT-1:0]        src_valid_i;
    logic [REQCNT*DATA_W-1:0] src_data_i;
    logic [REQCNT-1:0]        src_last_i;
    logic [REQCNT-1:0]        src_ready_o;
    logic                     m_valid_o;
    logic [DATA_W-1:0]        m_data_o;
    logic                     m_last_o;
    logic [IW-1:0]            m_src_o;
    logic                     m_ready_i;
    logic                     busy_o;
    logic                     timeout_o;

    modport slave (
        input  arb_num_i, arb_val_i, src_valid_i, src_data_i, src_last_i, m_ready_i,
        output arb_ack_o, src_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o,
               busy_o, timeout_o
    );

    modport master (
        output arb_num_i, arb_val_i, src_valid_i, src_data_i, src_last_i, m_ready_i,
        input  arb_ack_o, src_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o,
               busy_o, timeout_o
    );

endinterface

// File: rtl/rr_out_reg.sv
// Single-entry valid/ready output register: load, hold under backpressure, drain.
module rr_out_reg #(
    parameter int unsigned BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              ready,
    input  logic [BEAT_W-1:0] din,
    output logic              valid,
    output logic [BEAT_W-1:0] dout
);

    // Caller only loads when the slot is empty or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_grant_mux.sv
// Holds the arbiter's winner for a whole packet and routes its stream to one registered output.
// Optional forced release after HOLD_MAX idle BUSY cycles: define RR_GRANT_TIMEOUT_EN.
module rr_grant_mux
    import rr_pkg::*;
#(
    parameter int unsigned REQCNT   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_MAX = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rr_grant_mux_if.slave         bus
);
    localparam int unsigned IW     = idx_w(REQCNT);
    localparam int unsigned BEAT_W = DATA_W + 1 + IW;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [IW-1:0]     src;
    } beat_t;

    state_e            state_q, state_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic              ack_q, ack_d;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              out_valid, out_free, hs, expire;
    beat_t             in_beat, out_beat;

    // Select the granted source's stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < REQCNT; k++) begin
            if (gnt_q == IW'(k)) begin
                sel_valid = bus.src_valid_i[k];
                sel_last  = bus.src_last_i[k];
                sel_data  = bus.src_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_free = !out_valid || bus.m_ready_i;
    assign hs       = (state_q == BUSY) && sel_valid && out_free;
    assign in_beat  = '{data: sel_data, last: sel_last, src: gnt_q};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.arb_val_i && (32'(bus.arb_num_i) < 32'(REQCNT))) begin
                    gnt_d   = bus.arb_num_i;
                    ack_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if ((hs && sel_last) || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    // Fires on the idle cycle that would bring the counter to HOLD_MAX.
    assign expire = (state_q == BUSY) && !hs && (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= expire;
            if (ack_d || hs) begin
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.timeout_o = tmo_q;
`else
    logic unused_hold_max;

    assign unused_hold_max = ^32'(HOLD_MAX);
    assign expire          = 1'b0;
    assign bus.timeout_o   = 1'b0;
`endif

    rr_out_reg #(
        .BEAT_W (BEAT_W)
    ) u_out_reg (
        .clk   (clk_i),
        .rst_n (rst_i),
        .load  (hs),
        .ready (bus.m_ready_i),
        .din   (in_beat),
        .valid (out_valid),
        .dout  (out_beat)
    );

    assign bus.src_ready_o = ((state_q == BUSY) && out_free) ? (REQCNT'(1) << gnt_q) : '0;
    assign bus.arb_ack_o   = ack_q;
    assign bus.busy_o      = (state_q == BUSY);
    assign bus.m_valid_o   = out_valid;
    assign bus.m_data_o    = out_beat.data;
    assign bus.m_last_o    = out_beat.last;
    assign bus.m_src_o     = out_beat.src;

endmodule

// File: tb/tb_rr_grant_mux.sv
// Directed self-checking bench for rr_grant_mux (REQCNT=12, DATA_W=8, HOLD_MAX=8).
module tb_rr_grant_mux;
    localparam int unsigned REQCNT   = 12;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned HOLD_MAX = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    rr_grant_mux_if #(.REQCNT(REQCNT), .DATA_W(DATA_W)) bus ();

    rr_grant_mux #(
        .REQCNT   (REQCNT),
        .DATA_W   (DATA_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.arb_num_i   = '0;
        bus.arb_val_i   = 1'b0;
        bus.src_valid_i = '0;
        bus.src_data_i  = '0;
        bus.src_last_i  = '0;
        bus.m_ready_i   = 1'b1;
    endtask

    task automatic drive_src(input int k, input logic v, input logic [7:0] d, input logic l);
        bus.src_valid_i[k]          = v;
        bus.src_data_i[k*8 +: 8]    = d;
        bus.src_last_i[k]           = l;
    endtask

    task automatic grant(input int k);
        bus.arb_num_i = 4'(k);
        bus.arb_val_i = 1'b1;
        step();
        check("grant_ack", bus.arb_ack_o, 1);
        check("grant_busy", bus.busy_o, 1);
        bus.arb_val_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack", bus.arb_ack_o, 0);
        check("rst_mvalid", bus.m_valid_o, 0);
        check("rst_mdata", bus.m_data_o, 0);
        check("rst_msrc", bus.m_src_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_tmo", bus.timeout_o, 0);
        check("rst_ready", bus.src_ready_o, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single 4-beat packet from source 5.
        grant(5);
        for (int i = 0; i < 4; i++) begin
            drive_src(5, 1'b1, 8'(8'hA0 + i), (i == 3));
            #1;
            check("pkt_ready", bus.src_ready_o, 12'h020);
            step();
            check("pkt_ack_low", bus.arb_ack_o, 0);
            check("pkt_valid", bus.m_valid_o, 1);
            check("pkt_data", bus.m_data_o, 8'hA0 + i);
            check("pkt_src", bus.m_src_o, 5);
            check("pkt_last", bus.m_last_o, (i == 3));
        end
        check("pkt_busy_end", bus.busy_o, 0);
        drive_src(5, 1'b0, 8'h00, 1'b0);
        step();
        check("pkt_drained", bus.m_valid_o, 0);

        // Backpressure mid-packet.
        grant(5);
        drive_src(5, 1'b1, 8'hB0, 1'b0);
        step();
        check("bp_first", bus.m_data_o, 8'hB0);
        drive_src(5, 1'b1, 8'hB1, 1'b0);
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready_low", bus.src_ready_o, 0);
            step();
            check("bp_hold_valid", bus.m_valid_o, 1);
            check("bp_hold_data", bus.m_data_o, 8'hB0);
        end
        bus.m_ready_i = 1'b1;
        #1;
        check("bp_ready_back", bus.src_ready_o, 12'h020);
        step();
        check("bp_b1", bus.m_data_o, 8'hB1);
        drive_src(5, 1'b1, 8'hB2, 1'b1);
        step();
        check("bp_b2", bus.m_data_o, 8'hB2);
        check("bp_b2_last", bus.m_last_o, 1);
        drive_src(5, 1'b0, 8'h00, 1'b0);
        step();
        check("bp_drained", bus.m_valid_o, 0);

        // Grant exclusion: source 7 competes while source 3 holds the grant.
        grant(3);
        drive_src(7, 1'b1, 8'hFF, 1'b1);
        drive_src(3, 1'b1, 8'h30, 1'b0);
        bus.arb_num_i = 4'd7;
        bus.arb_val_i = 1'b1;
        #1;
        check("ex_ready", bus.src_ready_o, 12'h008);
        step();
        check("ex_no_ack", bus.arb_ack_o, 0);
        check("ex_data0", bus.m_data_o, 8'h30);
        check("ex_src0", bus.m_src_o, 3);
        drive_src(3, 1'b1, 8'h31, 1'b1);
        step();
        check("ex_data1", bus.m_data_o, 8'h31);
        check("ex_src1", bus.m_src_o, 3);
        check("ex_bubble_ack", bus.arb_ack_o, 0);
        check("ex_bubble_busy", bus.busy_o, 0);
        drive_src(3, 1'b0, 8'h00, 1'b0);
        step();
        check("ex_ack7", bus.arb_ack_o, 1);
        check("ex_busy7", bus.busy_o, 1);
        bus.arb_val_i = 1'b0;
        #1;
        check("ex_ready7", bus.src_ready_o, 12'h080);
        step();
        check("ex_data7", bus.m_data_o, 8'hFF);
        check("ex_src7", bus.m_src_o, 7);
        check("ex_end7", bus.busy_o, 0);
        drive_src(7, 1'b0, 8'h00, 1'b0);
        step();

        // Out-of-range indices are ignored; last valid index is accepted.
        bus.arb_num_i = 4'd13;
        bus.arb_val_i = 1'b1;
        step();
        check("inv13_ack", bus.arb_ack_o, 0);
        check("inv13_busy", bus.busy_o, 0);
        bus.arb_num_i = 4'd12;
        step();
        check("inv12_ack", bus.arb_ack_o, 0);
        check("inv12_busy", bus.busy_o, 0);
        grant(11);
        drive_src(11, 1'b1, 8'h5B, 1'b1);
        step();
        check("idx11_data", bus.m_data_o, 8'h5B);
        check("idx11_src", bus.m_src_o, 11);
        check("idx11_end", bus.busy_o, 0);
        drive_src(11, 1'b0, 8'h00, 1'b0);
        step();

        // Reset mid-packet.
        grant(2);
        drive_src(2, 1'b1, 8'h20, 1'b0);
        step();
        check("mr_beat", bus.m_data_o, 8'h20);
        drive_src(2, 1'b1, 8'h21, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", bus.m_valid_o, 0);
        check("mr_data", bus.m_data_o, 0);
        check("mr_src", bus.m_src_o, 0);
        check("mr_busy", bus.busy_o, 0);
        check("mr_ready", bus.src_ready_o, 0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_post_busy", bus.busy_o, 0);
        check("mr_post_valid", bus.m_valid_o, 0);
        check("mr_idle_ready", bus.src_ready_o, 0);
        drive_src(2, 1'b0, 8'h00, 1'b0);
        step();

        // Source stalls after one non-last beat.
        grant(1);
        drive_src(1, 1'b1, 8'h10, 1'b0);
        step();
        check("to_beat", bus.m_data_o, 8'h10);
        drive_src(1, 1'b0, 8'h00, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) check("to_drained", bus.m_valid_o, 0);
`ifdef RR_GRANT_TIMEOUT_EN
            check("to_pulse", bus.timeout_o, (c == 8));
            check("to_busy", bus.busy_o, (c != 8));
`else
            check("to_pulse", bus.timeout_o, 0);
            check("to_busy", bus.busy_o, 1);
`endif
        end
        step();
        check("to_pulse_end", bus.timeout_o, 0);
`ifdef RR_GRANT_TIMEOUT_EN
        check("to_idle", bus.busy_o, 0);
`else
        check("to_held", bus.busy_o, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_mux.md
Name: rr_grant_mux

Overview:
- Sits directly downstream of the round-robin arbiter top (rr_top).
- Consumes the arbiter's winner index and valid, latches it as the current grant, and holds it for a whole multi-beat packet.
- Routes the granted source's valid/data/last stream to a single registered master output with a valid/ready handshake.
- Pulses an acknowledge back to the arbiter when a grant is taken; requesters' src_valid_i bits feed the arbiter's req_i.

Parameters:
- REQCNT, 16, number of requesting sources (2..256, need not be a power of 2)
- DATA_W, 32, data beat width
- HOLD_MAX, 64, timeout threshold in cycles (used only with RR_GRANT_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- arb_num_i  in  $clog2(REQCNT)  winning source index from the arbiter
- arb_val_i  in  1  arb_num_i is valid
- arb_ack_o  out  1  one-cycle pulse: grant taken, arbiter may advance
- src_valid_i  in  REQCNT  per-source beat valid
- src_data_i  in  REQCNT*DATA_W  flattened per-source data; source k occupies bits [k*DATA_W +: DATA_W]
- src_last_i  in  REQCNT  per-source last-beat flag
- src_ready_o  out  REQCNT  per-source ready, one-hot or zero
- m_valid_o  out  1  output beat valid
- m_data_o  out  DATA_W  output data
- m_last_o  out  1  output last flag
- m_src_o  out  $clog2(REQCNT)  source index of the current output beat
- m_ready_i  in  1  downstream ready
- busy_o  out  1  grant held (state BUSY)
- timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_i=0, asynchronous) clears every output and register:
  - arb_ack_o, src_ready_o, m_valid_o, m_last_o, busy_o, timeout_o = 0
  - m_data_o, m_src_o = 0
  - state = IDLE
- State IDLE:
  - If arb_val_i=1 and arb_num_i<REQCNT: latch gnt_q<=arb_num_i, drive arb_ack_o=1 for exactly that cycle, next state BUSY.
  - If arb_num_i>=REQCNT: ignored; no ack, stay IDLE.
  - src_ready_o = 0 in IDLE.
- State BUSY:
  - src_ready_o[gnt_q] = out_free, where out_free = !m_valid_o || m_ready_i. All other ready bits are 0.
  - arb_val_i is ignored and arb_ack_o stays 0.
- Beat transfer:
  - On src_valid_i[gnt_q] && src_ready_o[gnt_q], the output register loads data, last and m_src_o<=gnt_q, and sets m_valid_o=1 on the next cycle (latency 1).
  - Full throughput: one beat per cycle while m_ready_i=1.
  - m_valid_o clears on m_ready_i=1 with no new load.
  - Output data is stable while m_valid_o=1 and m_ready_i=0.
- Packet end: when a beat with src_last_i=1 is accepted, the next state is IDLE.
  - This gives one bubble cycle before the next grant can be taken.
  - The last beat drains from the output register independently of the state.
- Non-granted src_valid_i are ignored; no data is ever dropped from the granted source.
- Source deasserting valid mid-packet: the grant is held, waiting (subject to the optional timeout).
- Reset mid-packet discards the output register contents; the source must retransmit.
- busy_o = (state==BUSY).

Optional Feature:
- RR_GRANT_TIMEOUT_EN defined:
  - A counter clears on grant and on every granted handshake, and increments each BUSY cycle with no handshake.
  - When it reaches HOLD_MAX: state->IDLE, timeout_o pulses 1 cycle, and the pending output beat still drains.
  - The counter width is $clog2(HOLD_MAX+1).
- Undefined: no counter; timeout_o tied 0; the grant is held indefinitely.

Decomposition:
- Shared package rr_pkg:
  - IDX_W function/localparam ($clog2 with a minimum of 1)
  - state enum {IDLE, BUSY}
  - a beat struct {data, last, src} parameterised via DATA_W in the module
- One natural sub-module, rr_out_reg: the single-entry valid/ready output register (load, hold, drain).

Test Plan:
- Reset mid-packet: source 2 sending a 3-beat packet, rst_i=0 after beat 1 → all outputs 0 asynchronously; after release, state IDLE and no stale m_valid_o.
- Single packet: arb_num_i=5, arb_val_i=1 → arb_ack_o pulses 1 cycle; src 5 sends 4 beats (0xA0..0xA3, last on 4th), m_ready_i=1 → m_data_o=0xA0..0xA3 with m_src_o=5 on consecutive cycles, each one cycle after input; m_last_o on 0xA3; busy_o drops after the last accept.
- Backpressure: m_ready_i=0 for 3 cycles mid-packet → src_ready_o[5]=0, m_data_o held stable; resume → no beat lost or duplicated.
- Grant exclusion: grant=3, src 7 valid with 0xFF, arb_val_i pulses with num=7 → src_ready_o[7]=0, no ack, only src 3 data appears; after src 3's last, num=7 is acked after one bubble cycle.
- Invalid index: REQCNT=12, arb_num_i=13, arb_val_i=1 → no ack, stays IDLE.
- With RR_GRANT_TIMEOUT_EN and HOLD_MAX=8: src 1 granted and sends 1 non-last beat, then stalls → timeout_o pulses exactly 8 cycles after that beat, busy_o=0; without the macro, busy_o stays 1.
